// File: rtl/dlbf_coeffs_stream_seq.sv
// rtl/dlbf_coeffs_stream_seq.sv - coefficient RAM reader streaming beamforming coefficients on AXI4-Stream
//
// Reads ni passes over a window of ro words from the coefficient RAM (port B)
// and streams them toward the AI Engine. Reads are only issued when the output
// FIFO has room for them, so RAM latency and downstream stalls never lose data.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   go               run starts on a 0->1 edge while idle
//   m_axis_rst       synchronous active-high soft reset (same effect as rstn)
//   block_size       beats per packet (0 treated as 1)
//   niter            passes over the RAM window
//   rollover_addr    words per pass (0 means the full 2^ADDR_W space)
//   addrb, enb       RAM port-B read address / enable
//   doutb            RAM read data, valid RAM_LAT cycles after enb
//   m_axis_*         output stream
//   done             run complete, held until go drops

module dlbf_coeffs_stream_seq #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 128,
    parameter int RAM_LAT = 2,
    parameter int FIFO_D  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    input  logic              m_axis_rst,
    input  logic [11:0]       block_size,
    input  logic [11:0]       niter,
    input  logic [15:0]       rollover_addr,
    output logic [ADDR_W-1:0] addrb,
    output logic              enb,
    input  logic [DATA_W-1:0] doutb,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // ro needs one extra bit so that a full 2^ADDR_W window is representable
    localparam int RO_W  = ADDR_W + 1;
    localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int OCC_W = $clog2(FIFO_D + RAM_LAT + 1) + 1;

    logic [1:0]          r_state;
    logic                r_go_d;
    logic [11:0]         r_bs;
    logic [11:0]         r_ni;
    logic [RO_W-1:0]     r_ro;
    logic [ADDR_W-1:0]   r_addrb;
    logic [11:0]         r_iter;
    logic [11:0]         r_beat;
    logic [RAM_LAT-1:0]  r_pipe;
    logic [OCC_W-1:0]    r_inflight;
    logic [OCC_W-1:0]    r_count;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [DATA_W-1:0]   r_mem [FIFO_D];

    logic                w_rst;
    logic                w_go_rise;
    logic                w_enb;
    logic                w_wrap;
    logic                w_last_read;
    logic                w_pipe_out;
    logic                w_tvalid;
    logic                w_xfer;
    logic                w_final_head;
    logic                w_tlast;
    logic [11:0]         w_bs_in;
    logic [RO_W-1:0]     w_ro_in;
    logic [ADDR_W-1:0]   w_ro_m1;

    assign w_rst     = !rstn || m_axis_rst;
    assign w_go_rise = go && !r_go_d;

    assign w_bs_in = (block_size == 12'd0) ? 12'd1 : block_size;
    assign w_ro_in = (rollover_addr == 16'd0) ? (RO_W'(1) << ADDR_W) : RO_W'(rollover_addr);
    assign w_ro_m1 = ADDR_W'(r_ro - RO_W'(1));

    // Credit rule: a read is issued only if its word is guaranteed a FIFO slot,
    // counting both stored words and reads still travelling through the RAM.
    assign w_enb       = (r_state == S_FETCH) && ((r_count + r_inflight) < OCC_W'(FIFO_D));
    assign w_wrap      = (r_addrb == w_ro_m1);
    assign w_last_read = w_enb && w_wrap && (r_iter == (r_ni - 12'd1));

    assign w_pipe_out = r_pipe[RAM_LAT-1];

    assign w_tvalid = (r_count != '0) && (r_state != S_DONE);
    assign w_xfer   = w_tvalid && m_axis_tready;

    // The head is the final beat of the run only once every read has been
    // issued and returned and it is the sole stored word. Nothing can arrive
    // behind it after that, so tlast stays stable while the beat is stalled.
    assign w_final_head = (r_state == S_DRAIN) && (r_count == OCC_W'(1)) && (r_inflight == '0);
    assign w_tlast      = w_tvalid && ((r_beat == (r_bs - 12'd1)) || w_final_head);

    assign addrb         = r_addrb;
    assign enb           = w_enb;
    assign m_axis_tdata  = r_mem[r_rd_ptr];
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tlast  = w_tlast;
    assign done          = (r_state == S_DONE);

    // Control FSM, address generation and packet beat counter
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state <= S_IDLE;
            r_go_d  <= go;
            r_bs    <= 12'd1;
            r_ni    <= '0;
            r_ro    <= '0;
            r_addrb <= '0;
            r_iter  <= '0;
            r_beat  <= '0;
        end else begin
            r_go_d <= go;

            if (w_xfer) begin
                r_beat <= w_tlast ? 12'd0 : r_beat + 12'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_go_rise) begin
                        r_bs    <= w_bs_in;
                        r_ni    <= niter;
                        r_ro    <= w_ro_in;
                        r_addrb <= '0;
                        r_iter  <= '0;
                        r_beat  <= '0;
                        r_state <= (niter == 12'd0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_enb) begin
                        if (w_wrap) begin
                            r_addrb <= '0;
                            r_iter  <= r_iter + 12'd1;
                        end else begin
                            r_addrb <= r_addrb + ADDR_W'(1);
                        end
                        if (w_last_read) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((w_xfer && w_final_head) || ((r_count == '0) && (r_inflight == '0))) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (!go) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // RAM read pipeline tracking and FIFO occupancy
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_pipe     <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_pipe     <= (r_pipe << 1) | RAM_LAT'(w_enb);
            r_inflight <= r_inflight + OCC_W'(w_enb) - OCC_W'(w_pipe_out);
            r_count    <= r_count + OCC_W'(w_pipe_out) - OCC_W'(w_xfer);
            if (w_pipe_out) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_D - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_xfer) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_D - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_pipe_out) begin
            r_mem[r_wr_ptr] <= doutb;
        end
    end

endmodule

// File: tb/tb_dlbf_coeffs_stream_seq.sv
// tb/tb_dlbf_coeffs_stream_seq.sv - self-checking bench for dlbf_coeffs_stream_seq

module tb_dlbf_coeffs_stream_seq;

    localparam int RAM_LAT = 2;
    localparam int FIFO_D  = 4;

    typedef struct {
        int ro;
        int ni;
        int bs;
        int pct;
        int exp_beats;
        int exp_tlasts;
    } vec_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         go;
    logic         m_axis_rst;
    logic [11:0]  block_size;
    logic [11:0]  niter;
    logic [15:0]  rollover_addr;
    logic         tready;

    logic [15:0]  addrb16;
    logic         enb16;
    logic [127:0] doutb16;
    logic [127:0] tdata16;
    logic         tvalid16;
    logic         tlast16;
    logic         done16;
    logic [15:0]  s1_16;

    logic [3:0]   addrb4;
    logic         enb4;
    logic [127:0] doutb4;
    logic [127:0] tdata4;
    logic         tvalid4;
    logic         tlast4;
    logic         done4;
    logic [3:0]   s1_4;

    bit           cur_sel;
    logic [127:0] s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_done;
    logic         s_enb;

    int checks   = 0;
    int failures = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    function automatic logic [127:0] data_of(input logic [15:0] a);
        return {16'hC0DE, a, 16'h1234 ^ a, ~a, 32'h0BEEF000 + {16'h0, a}, 16'h5A5A, a};
    endfunction

    // Two-cycle RAM models: address registered, then data registered
    always @(posedge clk) begin
        s1_16   <= addrb16;
        doutb16 <= data_of(s1_16);
        s1_4    <= addrb4;
        doutb4  <= data_of({12'h0, s1_4});
    end

    assign s_tdata  = cur_sel ? tdata4  : tdata16;
    assign s_tvalid = cur_sel ? tvalid4 : tvalid16;
    assign s_tlast  = cur_sel ? tlast4  : tlast16;
    assign s_done   = cur_sel ? done4   : done16;
    assign s_enb    = cur_sel ? enb4    : enb16;

    dlbf_coeffs_stream_seq #(.ADDR_W(16), .DATA_W(128), .RAM_LAT(RAM_LAT), .FIFO_D(FIFO_D)) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .go            (go),
        .m_axis_rst    (m_axis_rst),
        .block_size    (block_size),
        .niter         (niter),
        .rollover_addr (rollover_addr),
        .addrb         (addrb16),
        .enb           (enb16),
        .doutb         (doutb16),
        .m_axis_tdata  (tdata16),
        .m_axis_tvalid (tvalid16),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast16),
        .done          (done16)
    );

    dlbf_coeffs_stream_seq #(.ADDR_W(4), .DATA_W(128), .RAM_LAT(RAM_LAT), .FIFO_D(FIFO_D)) u_dut4 (
        .clk           (clk),
        .rstn          (rstn),
        .go            (go),
        .m_axis_rst    (m_axis_rst),
        .block_size    (block_size),
        .niter         (niter),
        .rollover_addr (rollover_addr),
        .addrb         (addrb4),
        .enb           (enb4),
        .doutb         (doutb4),
        .m_axis_tdata  (tdata4),
        .m_axis_tvalid (tvalid4),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast4),
        .done          (done4)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete run: start on go rise, score every beat against the model,
    // then drop go and confirm done clears.
    task automatic run(input int ro, input int ni, input int bs, input int pct,
                       input int exp_beats, input int exp_tlasts, input int sel);
        int ro_eff, bs_eff, total, k, nl, bc, cyc, issued, first_tv, last_cyc, max_out;
        bit got_done, stall, exp_last;
        logic [127:0] prev_d;
        logic prev_l;
        cur_sel  = (sel != 0);
        ro_eff   = (ro == 0) ? ((sel != 0) ? 16 : 65536) : ro;
        bs_eff   = (bs == 0) ? 1 : bs;
        total    = ni * ro_eff;
        k = 0; nl = 0; bc = 0; cyc = 0; issued = 0; first_tv = -1; last_cyc = -1; max_out = 0;
        got_done = 0; stall = 0; prev_d = '0; prev_l = 1'b0;
        block_size    = 12'(bs);
        niter         = 12'(ni);
        rollover_addr = 16'(ro);
        go = 1'b1;
        for (int c = 1; c <= 4000; c++) begin
            @(negedge clk);
            tready = ($urandom_range(99) < pct);
            cyc = c;
            if (s_done) begin
                got_done = 1;
                break;
            end
            if (stall) begin
                check("stall_valid", s_tvalid, 1'b1);
                check("stall_data", s_tdata, prev_d);
                check("stall_last", s_tlast, prev_l);
            end
            if (s_enb) issued++;
            if (s_tvalid && first_tv < 0) first_tv = c;
            if (s_tvalid && tready) begin
                exp_last = (bc == bs_eff - 1) || (k == total - 1);
                check("beat_data", s_tdata, data_of(16'(k % ro_eff)));
                check("beat_last", s_tlast, exp_last);
                bc = exp_last ? 0 : bc + 1;
                if (s_tlast) nl++;
                k++;
                last_cyc = c;
            end
            if (issued - k > max_out) max_out = issued - k;
            stall  = s_tvalid && !tready;
            prev_d = s_tdata;
            prev_l = s_tlast;
        end
        check("done_reached", got_done, 1'b1);
        check("done_tvalid_low", s_tvalid, 1'b0);
        check("beats", k, exp_beats);
        check("tlasts", nl, exp_tlasts);
        check("reads_issued", issued, total);
        if (exp_beats > 0) begin
            check("done_latency", cyc, last_cyc + 1);
            check("first_valid_min", first_tv >= RAM_LAT + 1, 1'b1);
        end else begin
            check("done_latency", cyc, 1);
        end
        check("fifo_bound", max_out <= FIFO_D, 1'b1);
        go = 1'b0;
        @(negedge clk);
        check("done_clear", s_done, 1'b0);
    endtask

    initial begin
        int k;
        bit seen_valid;
        vecs[0] = '{8,  2, 4, 100, 16, 4};
        vecs[1] = '{6,  1, 4, 100, 6,  2};
        vecs[2] = '{16, 1, 5, 30,  16, 4};
        vecs[3] = '{5,  3, 7, 50,  15, 3};
        vecs[4] = '{8,  0, 4, 100, 0,  0};
        vecs[5] = '{1,  3, 2, 100, 3,  2};

        rstn = 1'b0; go = 1'b0; m_axis_rst = 1'b0; tready = 1'b0;
        block_size = '0; niter = '0; rollover_addr = '0; cur_sel = 0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", tvalid16, 1'b0);
        check("rst_tlast", tlast16, 1'b0);
        check("rst_enb", enb16, 1'b0);
        check("rst_done", done16, 1'b0);
        check("rst_addrb", addrb16, 16'h0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].ro, vecs[i].ni, vecs[i].bs, vecs[i].pct, vecs[i].exp_beats, vecs[i].exp_tlasts, 0);
        end

        // Soft reset in the middle of a 4x32 run
        cur_sel = 0;
        block_size = 12'd8; niter = 12'd4; rollover_addr = 16'd32;
        tready = 1'b1; go = 1'b1; k = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (tvalid16 && tready) k++;
            if (k == 10) break;
        end
        check("srst_prebeats", k, 10);
        @(negedge clk);
        m_axis_rst = 1'b1; go = 1'b0; tready = 1'b0;
        @(negedge clk);
        check("srst_tvalid", tvalid16, 1'b0);
        check("srst_done", done16, 1'b0);
        check("srst_addrb", addrb16, 16'h0);
        check("srst_enb", enb16, 1'b0);
        m_axis_rst = 1'b0;
        tready = 1'b1;
        seen_valid = 0;
        repeat (8) begin
            @(negedge clk);
            if (tvalid16 || enb16) seen_valid = 1;
        end
        check("srst_quiet", seen_valid, 1'b0);
        run(32, 4, 8, 100, 128, 16, 0);

        // Full 2^ADDR_W window with block_size 0 on the 4-bit address instance
        m_axis_rst = 1'b1;
        @(negedge clk);
        m_axis_rst = 1'b0;
        @(negedge clk);
        run(0, 1, 0, 100, 16, 16, 1);
        check("wrap_addrb_end", addrb4, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
